// File: rtl/axi_rfifo.sv
`default_nettype none
// ============================================================================
// Module   : axi_rfifo
// Purpose  : AXI read-data (R) channel delay buffer. R beats arriving from the
//            pad-side memory model are stored in an in-order ENTRY_NUM-deep
//            FIFO and each one is held for a programmable number of cycles
//            before it is offered to the CPU BIU. It is the return path that
//            pairs with the read-address delay FIFO and is used to stress the
//            CPU's read-latency tolerance.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ENTRY_NUM   FIFO depth (one-hot pointers, one down-counter per entry)
//   DATA_WIDTH  rdata width
// Ports
//   cpu_clk          in   clock
//   cpu_rst_b        in   reset, asynchronous, active-low
//   pad_biu_rvalid   in   R beat valid from pad side
//   pad_biu_rdata    in   read data
//   pad_biu_rid      in   read ID
//   pad_biu_rresp    in   read response
//   pad_biu_rlast    in   last beat of burst
//   fifo_pad_rready  out  FIFO can accept a beat
//   delay_num        in   delay in cycles, sampled when a beat is accepted
//   fifo_biu_rvalid  out  delayed beat valid to BIU
//   fifo_biu_rdata   out  delayed data
//   fifo_biu_rid     out  delayed ID
//   fifo_biu_rresp   out  delayed response
//   fifo_biu_rlast   out  delayed last
//   biu_pad_rready   in   BIU accepts beat
// Configuration macro
//   AXI_RFIFO_FIRST_BEAT_DELAY_EN
//     defined   : only the first beat of each burst is loaded with delay_num,
//                 later beats of the same burst load a count of zero.
//     undefined : every beat is loaded with delay_num.
// ============================================================================
module axi_rfifo #(
    parameter int ENTRY_NUM  = 8,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_b,
    input  logic                  pad_biu_rvalid,
    input  logic [DATA_WIDTH-1:0] pad_biu_rdata,
    input  logic [7:0]            pad_biu_rid,
    input  logic [1:0]            pad_biu_rresp,
    input  logic                  pad_biu_rlast,
    output logic                  fifo_pad_rready,
    input  logic [31:0]           delay_num,
    output logic                  fifo_biu_rvalid,
    output logic [DATA_WIDTH-1:0] fifo_biu_rdata,
    output logic [7:0]            fifo_biu_rid,
    output logic [1:0]            fifo_biu_rresp,
    output logic                  fifo_biu_rlast,
    input  logic                  biu_pad_rready
);

    // Stored beat layout: {rdata, rid, rresp, rlast}
    localparam int                   C_ENTRY_W = DATA_WIDTH + 8 + 2 + 1;
    localparam logic [ENTRY_NUM-1:0] C_PTR_RST = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [ENTRY_NUM-1:0] r_entry_vld;
    logic [ENTRY_NUM-1:0] r_create_ptr;
    logic [ENTRY_NUM-1:0] r_pop_ptr;

    logic [ENTRY_NUM-1:0] w_entry_done;
    logic [ENTRY_NUM-1:0] w_create_sel;
    logic [ENTRY_NUM-1:0] w_pop_sel;

    logic                 w_create_en;
    logic                 w_pop_req;
    logic                 w_pop_en;
    logic [31:0]          w_load_cnt;

    logic [C_ENTRY_W-1:0] w_create_data;
    logic [C_ENTRY_W-1:0] w_pop_data;
    logic [C_ENTRY_W-1:0] w_pop_term [ENTRY_NUM];

    // ------------------------------------------------------------------------
    // Create side
    // ------------------------------------------------------------------------
    // Ready depends only on the slot under the create pointer, never on
    // rvalid, so the pad side sees no combinational loop through this block.
    assign fifo_pad_rready = ~(|(r_create_ptr & r_entry_vld));
    assign w_create_en     = pad_biu_rvalid & fifo_pad_rready;
    assign w_create_sel    = r_create_ptr & {ENTRY_NUM{w_create_en}};
    assign w_create_data   = {pad_biu_rdata, pad_biu_rid, pad_biu_rresp, pad_biu_rlast};

`ifdef AXI_RFIFO_FIRST_BEAT_DELAY_EN
    // Set by a non-last beat, cleared by the last beat: while set, the beat
    // being accepted belongs to a burst whose first beat already paid the
    // delay, so it is loaded with a zero count.
    logic r_in_burst;

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            r_in_burst <= 1'b0;
        end else if (w_create_en) begin
            r_in_burst <= ~pad_biu_rlast;
        end
    end

    assign w_load_cnt = r_in_burst ? 32'd0 : delay_num;
`else
    assign w_load_cnt = delay_num;
`endif

    // ------------------------------------------------------------------------
    // Pop side
    // ------------------------------------------------------------------------
    // Only the head entry may be presented; a finished entry behind a head
    // that is still counting waits its turn.
    assign w_pop_req = |(r_pop_ptr & r_entry_vld & w_entry_done);
    assign w_pop_en  = w_pop_req & biu_pad_rready;
    assign w_pop_sel = r_pop_ptr & {ENTRY_NUM{w_pop_en}};

    // ------------------------------------------------------------------------
    // Valid bits and pointers
    // ------------------------------------------------------------------------
    // A create can only target an empty slot and a pop only a full one, so
    // the set and clear masks never hit the same bit in one cycle.
    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            r_entry_vld <= '0;
        end else begin
            r_entry_vld <= (r_entry_vld | w_create_sel) & ~w_pop_sel;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            r_create_ptr <= C_PTR_RST;
        end else if (w_create_en) begin
            r_create_ptr <= {r_create_ptr[ENTRY_NUM-2:0], r_create_ptr[ENTRY_NUM-1]};
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
        if (!cpu_rst_b) begin
            r_pop_ptr <= C_PTR_RST;
        end else if (w_pop_en) begin
            r_pop_ptr <= {r_pop_ptr[ENTRY_NUM-2:0], r_pop_ptr[ENTRY_NUM-1]};
        end
    end

    // ------------------------------------------------------------------------
    // Per-entry storage and delay counter
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
        logic [31:0]          r_cnt;
        logic [C_ENTRY_W-1:0] r_data;

        // The counter saturates at zero: a finished entry stays finished
        // until it is popped, however long the BIU stalls.
        always_ff @(posedge cpu_clk or negedge cpu_rst_b) begin
            if (!cpu_rst_b) begin
                r_cnt  <= '0;
                r_data <= '0;
            end else if (w_create_sel[gi]) begin
                r_cnt  <= w_load_cnt;
                r_data <= w_create_data;
            end else if (r_entry_vld[gi] && (r_cnt != 32'd0)) begin
                r_cnt  <= r_cnt - 32'd1;
            end
        end

        assign w_entry_done[gi] = (r_cnt == 32'd0);
        assign w_pop_term[gi]   = r_data & {C_ENTRY_W{r_pop_ptr[gi]}};
    end

    // ------------------------------------------------------------------------
    // Output AND-OR mux
    // ------------------------------------------------------------------------
    // The pop pointer is one-hot, so OR-ing the masked entries selects the
    // head. Data follows the head slot even when it is empty; consumers only
    // look at it while rvalid is high.
    always_comb begin
        w_pop_data = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            w_pop_data = w_pop_data | w_pop_term[i];
        end
    end

    assign fifo_biu_rvalid = w_pop_req;
    assign fifo_biu_rdata  = w_pop_data[C_ENTRY_W-1 -: DATA_WIDTH];
    assign fifo_biu_rid    = w_pop_data[10:3];
    assign fifo_biu_rresp  = w_pop_data[2:1];
    assign fifo_biu_rlast  = w_pop_data[0];

endmodule
`default_nettype wire

// File: tb/tb_axi_rfifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rfifo
// Purpose  : Self-checking bench for axi_rfifo. Accepted beats are pushed to
//            a scoreboard with the cycle at which they may first appear; the
//            negedge monitor checks rvalid/rready every cycle and the beat
//            fields whenever a beat is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rfifo;

    localparam int DW    = 128;
    localparam int DEPTH = 8;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst_b = 1'b0;
    logic          pad_biu_rvalid = 1'b0;
    logic [DW-1:0] pad_biu_rdata = '0;
    logic [7:0]    pad_biu_rid = '0;
    logic [1:0]    pad_biu_rresp = '0;
    logic          pad_biu_rlast = 1'b0;
    logic          fifo_pad_rready;
    logic [31:0]   delay_num = '0;
    logic          fifo_biu_rvalid;
    logic [DW-1:0] fifo_biu_rdata;
    logic [7:0]    fifo_biu_rid;
    logic [1:0]    fifo_biu_rresp;
    logic          fifo_biu_rlast;
    logic          biu_pad_rready = 1'b0;

    axi_rfifo #(
        .ENTRY_NUM  (DEPTH),
        .DATA_WIDTH (DW)
    ) u_dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst_b       (cpu_rst_b),
        .pad_biu_rvalid  (pad_biu_rvalid),
        .pad_biu_rdata   (pad_biu_rdata),
        .pad_biu_rid     (pad_biu_rid),
        .pad_biu_rresp   (pad_biu_rresp),
        .pad_biu_rlast   (pad_biu_rlast),
        .fifo_pad_rready (fifo_pad_rready),
        .delay_num       (delay_num),
        .fifo_biu_rvalid (fifo_biu_rvalid),
        .fifo_biu_rdata  (fifo_biu_rdata),
        .fifo_biu_rid    (fifo_biu_rid),
        .fifo_biu_rresp  (fifo_biu_rresp),
        .fifo_biu_rlast  (fifo_biu_rlast),
        .biu_pad_rready  (biu_pad_rready)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Number of rising edges so far; at a negedge it names the edge that
    // opened the current cycle.
    int cyc = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    id;
        logic [1:0]    resp;
        logic          last;
        int            ready_cyc;
    } beat_t;

    beat_t sb[$];
    int    last_pop_edge = 0;
    bit    mdl_in_burst  = 1'b0;
    int    n_checks      = 0;
    int    n_fail        = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    always @(negedge cpu_clk) begin : mon
        logic  exp_vld;
        int    n_eff;
        beat_t b;
        if (cpu_rst_b) begin
            exp_vld = (sb.size() > 0) && (cyc >= sb[0].ready_cyc) && (cyc >= last_pop_edge);
            check_val("rvalid", 128'(fifo_biu_rvalid), 128'(exp_vld));
            check_val("rready_full", 128'(fifo_pad_rready), 128'(sb.size() < DEPTH));
            if (fifo_biu_rvalid && (sb.size() > 0)) begin
                check_val("rdata", fifo_biu_rdata, sb[0].data);
                check_val("rid", 128'(fifo_biu_rid), 128'(sb[0].id));
                check_val("rresp", 128'(fifo_biu_rresp), 128'(sb[0].resp));
                check_val("rlast", 128'(fifo_biu_rlast), 128'(sb[0].last));
                if (biu_pad_rready) begin
                    void'(sb.pop_front());
                    last_pop_edge = cyc + 1;
                end
            end
            if (pad_biu_rvalid && fifo_pad_rready) begin
                n_eff = int'(delay_num);
`ifdef AXI_RFIFO_FIRST_BEAT_DELAY_EN
                if (mdl_in_burst) n_eff = 0;
`endif
                mdl_in_burst = !pad_biu_rlast;
                b.data      = pad_biu_rdata;
                b.id        = pad_biu_rid;
                b.resp      = pad_biu_rresp;
                b.last      = pad_biu_rlast;
                b.ready_cyc = cyc + 1 + n_eff;
                sb.push_back(b);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers (all return at posedge + #1)
    // ------------------------------------------------------------------------
    task automatic send(input logic [DW-1:0] d, input logic [7:0] id, input logic [1:0] rs,
                        input logic last, input logic [31:0] dly);
        bit done;
        done           = 1'b0;
        pad_biu_rvalid = 1'b1;
        pad_biu_rdata  = d;
        pad_biu_rid    = id;
        pad_biu_rresp  = rs;
        pad_biu_rlast  = last;
        delay_num      = dly;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge cpu_clk);
            if (fifo_pad_rready) done = 1'b1;
        end
        @(posedge cpu_clk);
        #1;
        pad_biu_rvalid = 1'b0;
        if (!done) check_val("send_timeout", 128'(done), 128'(1));
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 400 && !empty; i++) begin
            @(negedge cpu_clk);
            if (sb.size() == 0 && !fifo_biu_rvalid) empty = 1'b1;
        end
        check_val("drain", 128'(sb.size()), 128'(0));
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge cpu_clk);
        #1;
        cpu_rst_b      = 1'b0;
        pad_biu_rvalid = 1'b0;
        biu_pad_rready = 1'b0;
        sb.delete();
        mdl_in_burst   = 1'b0;
        last_pop_edge  = 0;
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst_b = 1'b1;
        @(negedge cpu_clk);
        check_val("rst_rready", 128'(fifo_pad_rready), 128'(1));
        check_val("rst_rvalid", 128'(fifo_biu_rvalid), 128'(0));
        check_val("rst_rdata", fifo_biu_rdata, 128'(0));
        check_val("rst_rid", 128'(fifo_biu_rid), 128'(0));
        check_val("rst_rresp", 128'(fifo_biu_rresp), 128'(0));
        check_val("rst_rlast", 128'(fifo_biu_rlast), 128'(0));
        @(posedge cpu_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    bit rnd_on;

    initial begin
        reset_dut();

        // Single beat, delay 5
        biu_pad_rready = 1'b1;
        send(rnd_data(), 8'h5A, 2'd0, 1'b1, 32'd5);
        drain();

        // Fill to full with the BIU stalled, then a single pop frees one slot
        biu_pad_rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send(rnd_data(), 8'(i), 2'(i), 1'b1, 32'd0);
        end
        fork
            send(rnd_data(), 8'd8, 2'd3, 1'b1, 32'd0);
            begin
                repeat (4) @(posedge cpu_clk);
                #1 biu_pad_rready = 1'b1;
                @(posedge cpu_clk);
                #1 biu_pad_rready = 1'b0;
            end
        join
        biu_pad_rready = 1'b1;
        drain();

        // Long-delay head blocks a zero-delay follower
        send(rnd_data(), 8'hA0, 2'd1, 1'b1, 32'd10);
        send(rnd_data(), 8'hB0, 2'd2, 1'b1, 32'd0);
        drain();

        // Presented beat held for 4 stalled cycles
        biu_pad_rready = 1'b0;
        send(rnd_data(), 8'hC3, 2'd2, 1'b1, 32'd2);
        for (int i = 0; i < 50 && !fifo_biu_rvalid; i++) @(posedge cpu_clk);
        repeat (4) @(posedge cpu_clk);
        #1 biu_pad_rready = 1'b1;
        drain();

        // Four-beat burst, delay 3
        for (int i = 0; i < 4; i++) begin
            send(rnd_data(), 8'h40 + 8'(i), 2'd0, (i == 3), 32'd3);
        end
        drain();

        // Random traffic with random BIU back-pressure
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(rnd_data(), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 1)),
                         32'($urandom_range(0, 6)));
                end
                rnd_on = 1'b0;
            end
            begin
                for (int i = 0; i < 4000 && rnd_on; i++) begin
                    @(posedge cpu_clk);
                    #1 biu_pad_rready = 1'($urandom_range(0, 1));
                end
            end
        join
        biu_pad_rready = 1'b1;
        drain();

        // Reset in the middle of a burst discards everything
        biu_pad_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(rnd_data(), 8'h70 + 8'(i), 2'd0, 1'b0, 32'd20);
        end
        reset_dut();
        biu_pad_rready = 1'b1;
        send(rnd_data(), 8'h99, 2'd1, 1'b1, 32'd2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
